// File: rtl/i2c_pkg.sv
// Shared types and constants for the two-requester I2C address-phase master.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACK,
        STOP,
        DONE
    } state_t;

    localparam int I2C_NBITS  = 8;
    localparam int I2C_ADDR_W = 7;

endpackage

// File: rtl/tick_i2c.sv
// Quarter-period timebase: one-cycle tick at the end of every quarter of an
// SCL bit period, plus a wrapping 2-bit quarter index.
module tick_i2c #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    output logic       o_tick,
    output logic [1:0] o_quarter
);

    localparam int            QW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(DIV - 1);

    logic [QW-1:0] r_cnt;
    logic [1:0]    r_quarter;

    assign o_tick    = (r_cnt == Q_LAST);
    assign o_quarter = r_quarter;

    // Count cycles within a quarter; advance the quarter index on each tick.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt     <= '0;
            r_quarter <= 2'd0;
        end else if (o_tick) begin
            r_cnt     <= '0;
            r_quarter <= r_quarter + 2'd1;
        end else begin
            r_cnt     <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/arb_i2c_mestre.sv
// Round-robin arbiter plus I2C address-phase serialiser for two requesters.
// Each grant produces START, 7-bit address, R/W, ACK slot and STOP.
module arb_i2c_mestre
    import i2c_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [I2C_ADDR_W-1:0] endereco_0,
    input  logic [I2C_ADDR_W-1:0] endereco_1,
    input  logic                  op_0,
    input  logic                  op_1,
    output logic [1:0]            gnt,
    output logic                  ocupado,
    output logic                  done,
    output logic                  scl,
    output logic                  sda
);

    state_t                 r_state, w_nextState;
    logic [I2C_NBITS-1:0]   r_shift, w_nextShift;
    logic [3:0]             r_bitCnt, w_nextBitCnt;
    logic [1:0]             r_gnt, w_nextGnt;
    logic                   r_ultimo, w_nextUltimo;
    logic                   w_sel;
    logic                   w_tick;
    logic [1:0]             w_quarter;
    logic                   w_clear;
    logic                   w_bitEnd;

    // The timebase is held clear outside a transaction so every START is aligned.
    assign w_clear  = (r_state == IDLE) || (r_state == DONE);
    assign w_bitEnd = w_tick && (w_quarter == 2'd3);
    assign ocupado  = |gnt;

    tick_i2c #(.DIV(DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .o_tick    (w_tick),
        .o_quarter (w_quarter)
    );

    // State, shift register, bit counter, grant and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitCnt <= 4'd0;
            r_gnt    <= 2'b00;
            r_ultimo <= 1'b1;
        end else begin
            r_state  <= w_nextState;
            r_shift  <= w_nextShift;
            r_bitCnt <= w_nextBitCnt;
            r_gnt    <= w_nextGnt;
            r_ultimo <= w_nextUltimo;
        end
    end

    // Arbitration, sequencing and bus-line decode from the current state/quarter.
    always_comb begin
        w_nextState  = r_state;
        w_nextShift  = r_shift;
        w_nextBitCnt = r_bitCnt;
        w_nextGnt    = r_gnt;
        w_nextUltimo = r_ultimo;
        w_sel        = 1'b0;
        gnt          = 2'b00;
        done         = 1'b0;
        scl          = 1'b1;
        sda          = 1'b1;

        case (r_state)
            IDLE: begin
                if (req != 2'b00) begin
                    if (req == 2'b01)      w_sel = 1'b0;
                    else if (req == 2'b10) w_sel = 1'b1;
                    else                   w_sel = ~r_ultimo;
                    w_nextGnt    = w_sel ? 2'b10 : 2'b01;
                    w_nextUltimo = w_sel;
                    w_nextShift  = w_sel ? {endereco_1, op_1} : {endereco_0, op_0};
                    w_nextBitCnt = 4'd0;
                    w_nextState  = START;
                end
            end
            START: begin
                gnt = r_gnt;
                sda = ~w_quarter[1];
                if (w_bitEnd) w_nextState = DATA;
            end
            DATA: begin
                gnt = r_gnt;
                scl = w_quarter[1];
                sda = r_shift[I2C_NBITS-1];
                if (w_bitEnd) begin
                    w_nextShift = {r_shift[I2C_NBITS-2:0], 1'b0};
                    if (r_bitCnt == 4'(I2C_NBITS - 1)) begin
                        w_nextState = ACK;
                    end else begin
                        w_nextBitCnt = r_bitCnt + 4'd1;
                    end
                end
            end
            ACK: begin
                gnt = r_gnt;
                scl = w_quarter[1];
                if (w_bitEnd) w_nextState = STOP;
            end
            STOP: begin
                gnt = r_gnt;
                scl = w_quarter[1];
                sda = (w_quarter == 2'd3);
                if (w_bitEnd) w_nextState = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_arb_i2c_mestre.sv
// Directed bench for arb_i2c_mestre: three instances (DIV = 2, 1, 4) share the
// clock, reset and address inputs; each has its own request and outputs.
module tb_arb_i2c_mestre;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] endereco_0 = 7'h00;
    logic [6:0] endereco_1 = 7'h00;
    logic       op_0 = 1'b0;
    logic       op_1 = 1'b0;
    logic [1:0] req [3];
    logic [1:0] gnt [3];
    logic       ocupado [3];
    logic       done [3];
    logic       scl [3];
    logic       sda [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_i2c_mestre #(.DIV(2)) u_dut2 (
        .clk(clk), .reset(reset), .req(req[0]),
        .endereco_0(endereco_0), .endereco_1(endereco_1), .op_0(op_0), .op_1(op_1),
        .gnt(gnt[0]), .ocupado(ocupado[0]), .done(done[0]), .scl(scl[0]), .sda(sda[0])
    );

    arb_i2c_mestre #(.DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req[1]),
        .endereco_0(endereco_0), .endereco_1(endereco_1), .op_0(op_0), .op_1(op_1),
        .gnt(gnt[1]), .ocupado(ocupado[1]), .done(done[1]), .scl(scl[1]), .sda(sda[1])
    );

    arb_i2c_mestre #(.DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .req(req[2]),
        .endereco_0(endereco_0), .endereco_1(endereco_1), .op_0(op_0), .op_1(op_1),
        .gnt(gnt[2]), .ocupado(ocupado[2]), .done(done[2]), .scl(scl[2]), .sda(sda[2])
    );

    function automatic int divOf(input int idx);
        case (idx)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    // Continuous protocol watch on all instances: SDA may only move while SCL
    // is high at the START fall and STOP rise; grant one-hot or zero; ocupado == |gnt.
    task automatic monitorBus();
        logic       prevScl [3];
        logic       prevSda [3];
        logic [1:0] prevGnt [3];
        int         cyc [3];
        logic       prevRst;
        logic       allowed;
        int         d;
        prevRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prevScl[i] = 1'b1;
            prevSda[i] = 1'b1;
            prevGnt[i] = 2'b00;
            cyc[i]     = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                d = divOf(i);
                if (gnt[i] != 2'b00 && prevGnt[i] == 2'b00) cyc[i] = 1;
                else if (gnt[i] != 2'b00)                    cyc[i] = cyc[i] + 1;
                else                                         cyc[i] = 0;
                if (!reset && !prevRst) begin
                    allowed = (gnt[i] != 2'b00) &&
                              ((cyc[i] == 2 * d + 1 && sda[i] == 1'b0) ||
                               (cyc[i] == 43 * d + 1 && sda[i] == 1'b1));
                    checks++;
                    if (prevScl[i] === 1'b1 && scl[i] === 1'b1 && sda[i] !== prevSda[i] && !allowed) begin
                        errors++;
                        $display("[TB] FAIL protocol inst%0d: sda moved %b->%b with scl high at txn cycle %0d (required: stable)",
                                 i, prevSda[i], sda[i], cyc[i]);
                    end
                    checks++;
                    if (!(gnt[i] === 2'b00 || gnt[i] === 2'b01 || gnt[i] === 2'b10) ||
                        ocupado[i] !== (gnt[i] != 2'b00)) begin
                        errors++;
                        $display("[TB] FAIL gnt_onehot inst%0d: gnt=%b ocupado=%b (required: one-hot/zero, ocupado=|gnt)",
                                 i, gnt[i], ocupado[i]);
                    end
                end
                prevScl[i] = scl[i];
                prevSda[i] = sda[i];
                prevGnt[i] = gnt[i];
            end
            prevRst = reset;
        end
    endtask

    // Runs for a fixed budget after req was set just before edge T; captures
    // SDA at the first 9 SCL rising edges, the done cycle and the k=1 grant.
    task automatic runTxn(input int idx, input int budget, input int dropAt, input int chgAt,
                          output logic [8:0] bits, output int doneAt,
                          output logic [1:0] gntFirst, output int donePulses);
        int   nEdge;
        logic prevScl;
        bits       = '0;
        doneAt     = -1;
        donePulses = 0;
        gntFirst   = 2'bxx;
        nEdge      = 0;
        prevScl    = scl[idx];
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) gntFirst = gnt[idx];
            if (scl[idx] && !prevScl) begin
                if (nEdge < 9) bits[8 - nEdge] = sda[idx];
                nEdge++;
            end
            prevScl = scl[idx];
            if (done[idx]) begin
                donePulses++;
                if (doneAt < 0) doneAt = k;
            end
            if (k == dropAt) req[idx] = 2'b00;
            if (k == chgAt)  endereco_0 = 7'h00;
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gnt[i] !== 2'b00 || ocupado[i] !== 1'b0 || done[i] !== 1'b0 ||
                scl[i] !== 1'b1 || sda[i] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_state inst%0d: gnt=%b ocp=%b done=%b scl=%b sda=%b (required 00 0 0 1 1)",
                         i, gnt[i], ocupado[i], done[i], scl[i], sda[i]);
            end
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_div2();
        logic [8:0] bits;
        int         doneAt, pulses;
        logic [1:0] g;
        endereco_0 = 7'h2A;
        op_0       = 1'b0;
        @(negedge clk);
        req[0] = 2'b01;
        runTxn(0, 100, 1, -1, bits, doneAt, g, pulses);
        checks++;
        if (g !== 2'b01) begin
            errors++;
            $display("[TB] FAIL single_gnt: got %b required 01", g);
        end
        checks++;
        if (bits !== 9'b010101001) begin
            errors++;
            $display("[TB] FAIL single_bits: got %b required 010101001", bits);
        end
        checks++;
        if (doneAt != 89) begin
            errors++;
            $display("[TB] FAIL single_done_cycle: got %0d required 89", doneAt);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL single_done_pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int         nRise, nFall;
        int         riseAt [3];
        int         fallAt [3];
        logic [1:0] riseVal [3];
        logic [1:0] prevG;
        logic [1:0] expVal [3];
        int         expAt [3];
        expVal = '{2'b01, 2'b10, 2'b01};
        expAt  = '{1, 91, 181};
        applyReset();
        endereco_0 = 7'h11;
        endereco_1 = 7'h22;
        nRise = 0;
        nFall = 0;
        for (int j = 0; j < 3; j++) begin
            riseAt[j] = -1; fallAt[j] = -1; riseVal[j] = 2'b00;
        end
        @(negedge clk);
        req[0] = 2'b11;
        prevG  = gnt[0];
        for (int k = 1; k <= 185; k++) begin
            @(negedge clk);
            if (gnt[0] != 2'b00 && prevG == 2'b00 && nRise < 3) begin
                riseAt[nRise] = k; riseVal[nRise] = gnt[0]; nRise++;
            end
            if (gnt[0] == 2'b00 && prevG != 2'b00 && nFall < 3) begin
                fallAt[nFall] = k; nFall++;
            end
            prevG = gnt[0];
        end
        req[0] = 2'b00;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (riseVal[j] !== expVal[j] || riseAt[j] != expAt[j]) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d: got %b at %0d required %b at %0d",
                         j, riseVal[j], riseAt[j], expVal[j], expAt[j]);
            end
        end
        checks++;
        if (riseAt[1] - fallAt[0] != 2) begin
            errors++;
            $display("[TB] FAIL rr_gap: got %0d idle cycles required 2", riseAt[1] - fallAt[0]);
        end
        repeat (100) @(negedge clk);
    endtask

    task automatic test_div1_ones();
        logic [8:0] bits;
        int         doneAt, pulses;
        logic [1:0] g;
        endereco_1 = 7'h7F;
        op_1       = 1'b1;
        @(negedge clk);
        req[1] = 2'b10;
        runTxn(1, 55, 1, -1, bits, doneAt, g, pulses);
        checks++;
        if (g !== 2'b10) begin
            errors++;
            $display("[TB] FAIL div1_gnt: got %b required 10", g);
        end
        checks++;
        if (bits !== 9'b111111111) begin
            errors++;
            $display("[TB] FAIL div1_bits: got %b required 111111111", bits);
        end
        checks++;
        if (doneAt != 45 || pulses != 1) begin
            errors++;
            $display("[TB] FAIL div1_done: got cycle %0d pulses %0d required 45 and 1", doneAt, pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] bits;
        int         doneAt, pulses, seenDone;
        logic [1:0] g;
        endereco_0 = 7'h2A;
        op_0       = 1'b0;
        seenDone   = 0;
        @(negedge clk);
        req[2] = 2'b01;
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            if (k == 1) req[2] = 2'b00;
            if (done[2]) seenDone++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (scl[2] !== 1'b1 || sda[2] !== 1'b1 || gnt[2] !== 2'b00 || ocupado[2] !== 1'b0 || done[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_state: scl=%b sda=%b gnt=%b ocp=%b done=%b required 1 1 00 0 0",
                     scl[2], sda[2], gnt[2], ocupado[2], done[2]);
        end
        repeat (100) begin
            @(negedge clk);
            if (done[2]) seenDone++;
        end
        checks++;
        if (seenDone != 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_done: got %0d pulses required 0", seenDone);
        end
        @(negedge clk);
        req[2] = 2'b01;
        runTxn(2, 190, 1, -1, bits, doneAt, g, pulses);
        checks++;
        if (g !== 2'b01 || bits !== 9'b010101001) begin
            errors++;
            $display("[TB] FAIL midreset_regrant: got gnt %b bits %b required 01 010101001", g, bits);
        end
        checks++;
        if (doneAt != 177 || pulses != 1) begin
            errors++;
            $display("[TB] FAIL midreset_done: got cycle %0d pulses %0d required 177 and 1", doneAt, pulses);
        end
    endtask

    task automatic test_req_change();
        logic [8:0] bits;
        int         doneAt, pulses;
        logic [1:0] g;
        endereco_0 = 7'h2A;
        op_0       = 1'b1;
        @(negedge clk);
        req[0] = 2'b01;
        runTxn(0, 100, 20, 20, bits, doneAt, g, pulses);
        checks++;
        if (bits !== 9'b010101011) begin
            errors++;
            $display("[TB] FAIL latched_bits: got %b required 010101011", bits);
        end
        checks++;
        if (doneAt != 89 || pulses != 1) begin
            errors++;
            $display("[TB] FAIL latched_done: got cycle %0d pulses %0d required 89 and 1", doneAt, pulses);
        end
    endtask

    // Directed scenarios in sequence, with the protocol watcher running alongside.
    initial begin
        for (int i = 0; i < 3; i++) req[i] = 2'b00;
        fork
            monitorBus();
        join_none
        test_reset();
        test_single_div2();
        test_back_to_back();
        test_div1_ones();
        test_reset_mid();
        test_req_change();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_i2c_mestre.md
# arb_i2c_mestre

Two-requester I2C bus master that arbitrates access to the shared SCL/SDA lines and serialises one address-phase transaction per grant: START, 7-bit address (MSB first), R/W bit, ACK slot, STOP. It sits upstream of the address decoder on the same bus and is the only block allowed to drive `scl`/`sda`. Its purpose is to generate well-formed address phases for on-chip slaves from two independent request sources with round-robin fairness.

## Interface
- `DIV`, 4, clk cycles per SCL quarter-period (≥1); one bit period = 4·DIV cycles
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  2  request per requester (bit i = requester i), level-sensitive
- `endereco_0`  in  7  target address of requester 0
- `endereco_1`  in  7  target address of requester 1
- `op_0`  in  1  R/W bit of requester 0 (1 = read)
- `op_1`  in  1  R/W bit of requester 1
- `gnt`  out  2  one-hot grant, held for whole transaction; reset 2'b00
- `ocupado`  out  1  transaction in progress (gnt ≠ 0); reset 0
- `done`  out  1  one-cycle pulse at transaction end; reset 0
- `scl`  out  1  bus clock; idle/reset 1
- `sda`  out  1  bus data; idle/reset 1

## Operation
- States: IDLE, START, DATA, ACK, STOP, DONE.
- IDLE: `scl` = 1, `sda` = 1. If any `req` bit is set, arbitrate:
  - If only one bit is set, grant that requester.
  - If both are set, grant the requester not granted last (`ultimo` pointer).
  - Latch `{endereco_i, op_i}` into an 8-bit shift register, set `gnt`, update `ultimo`, go to START.
- START (4·DIV cycles): `scl` = 1 throughout; `sda` = 1 for the first 2·DIV cycles, then 0.
- DATA (8 bits × 4·DIV cycles), per bit:
  - Quarters 0–1: `scl` = 0, `sda` = shift register MSB, set at the start of quarter 0.
  - Quarters 2–3: `scl` = 1, `sda` held.
  - Shift left after quarter 3. Bit counter runs 0..7; the 8th bit is the R/W bit.
- ACK (4·DIV): same SCL pattern, `sda` = 1 (released). The ACK value is not sampled.
- STOP (4·DIV):
  - Quarters 0–1: `scl` = 0, `sda` = 0.
  - Quarter 2: `scl` = 1, `sda` = 0.
  - Quarter 3: `scl` = 1, `sda` = 1.
- DONE (1 cycle): `done` = 1, `gnt` = 0, `ocupado` = 0, `scl` = `sda` = 1. Next state IDLE.
- Request and address changes after grant are ignored; the latched copy is used. Dropping `req` mid-transaction does not abort it.
- `ultimo` resets to requester 1, so requester 0 wins the first tie after reset.
- Reset mid-transaction: on the next edge all outputs return to reset values and state goes to IDLE. No STOP is generated and no `done` pulse occurs.

## Timing
- `req` sampled in IDLE at cycle T. `gnt`/`ocupado` rise at T+1, which is the first START cycle.
- Bus activity occupies cycles T+1 .. T+44·DIV. `done` is high at T+44·DIV+1, the same cycle `gnt` falls.
- IDLE at T+44·DIV+2 samples `req`. The earliest next `gnt` is T+44·DIV+3, a 2-cycle bus-idle gap.
- SCL rising edges fall on quarter-2 boundaries. SDA never changes while `scl` = 1, except the START fall and the STOP rise.
- Quarter counter width is $clog2(DIV) (minimum 1); it wraps at DIV−1. Bit counter is 4 bits.

## Structure
- Shared package `i2c_pkg`: `state_t` enum (IDLE, START, DATA, ACK, STOP, DONE), `I2C_NBITS` = 8, `I2C_ADDR_W` = 7.
- One sub-module, `tick_i2c`: parameter DIV, outputs a one-cycle `tick` at each quarter end plus a 2-bit quarter index. It is cleared by `reset` and by leaving IDLE, so every transaction starts aligned.

## Test plan
- DIV=2, `req`=01, `endereco_0`=7'h2A, `op_0`=0:
  - `gnt`=01 one cycle after request.
  - `sda` at the 9 SCL rising edges = 0,1,0,1,0,1,0,0 then ACK 1.
  - `done` at cycle 89 relative to sampling.
- DIV=2, `req`=11 right after reset: requester 0 is served first. With `req` held at 11, the grants alternate 01,10,01, each separated by a 2-cycle gap.
- DIV=1, `req`=10, `endereco_1`=7'h7F, `op_1`=1:
  - `sda` = 1 at every data edge.
  - START fall and STOP rise occur only while `scl` = 1.
  - `done` at +45.
- DIV=4: assert `reset` during DATA bit 3. Next cycle `scl`=`sda`=1, `gnt`=00, `ocupado`=0, and `done` never pulses. A request after release is granted normally.
- DIV=2: deassert `req` and change `endereco_0` to 7'h00 mid-DATA. The original address is still shifted out in full and `done` pulses once.
- Bus protocol check on every test: no SDA edge while `scl` = 1 other than START/STOP, and `gnt` is always one-hot or zero.
